// File: rtl/gray_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_sweep_ctrl_pkg
//  Description : Shared constants and helpers for the Gray sweep sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_sweep_ctrl_pkg;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 8;

    // True when a code width is supported by the sequencer
    function automatic bit width_ok(input int w);
        return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_sweep_ctrl_bin2gray_conv.sv
`default_nettype none
// ============================================================================
//  Module      : bin2gray_conv
//  Description : Combinational binary-to-Gray converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2gray_conv #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule
`default_nettype wire

// File: rtl/gray_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_sweep_ctrl
//  Description : Steps a binary code through an inclusive, wrapping range and
//                presents each code with its Gray equivalent over valid/ready,
//                inserting a fixed dwell gap after every accepted code.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_sweep_ctrl
    import gray_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] first_i,
    input  logic [WIDTH-1:0] last_i,
    input  logic             stop_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] bin_out_o,
    output logic [WIDTH-1:0] gray_out_o,
    output logic [WIDTH:0]   count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("gray_sweep_ctrl: WIDTH out of range 2..8");
        end
        if ((DWELL < 0) || (DWELL > 255)) begin : g_bad_dwell
            $error("gray_sweep_ctrl: DWELL out of range 0..255");
        end
    endgenerate

    // Dwell counter counts down from DWELL-1 to 0, giving exactly DWELL idle cycles
    localparam logic [7:0]       c_DWELL_LOAD = 8'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [WIDTH-1:0] c_BIN_ONE    = WIDTH'(1);
    localparam logic [WIDTH:0]   c_CNT_ONE    = (WIDTH+1)'(1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] bin_q,     bin_d;
    logic [WIDTH-1:0] gray_q,    gray_d;
    logic [WIDTH-1:0] last_q,    last_d;
    logic [WIDTH:0]   count_q,   count_d;
    logic [7:0]       dwell_q,   dwell_d;
    logic             aborted_q, aborted_d;

    logic w_hs;
    logic w_final;

    assign w_hs    = (state_q == ST_EMIT) && out_ready_i;
    assign w_final = (bin_q == last_q);

    // Gray is computed from the next binary value so both registers load together
    bin2gray_conv #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop wins over any same-cycle handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (w_hs) begin
                    if (w_final)        state_d = ST_FIN;
                    else if (DWELL > 0) state_d = ST_DWELL;
                    else                state_d = ST_EMIT;
                end
            end
            ST_DWELL: begin
                if (stop_i)              state_d = ST_IDLE;
                else if (dwell_q == '0)  state_d = ST_EMIT;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; a stop in FIN suppresses that sweep's done
    always_comb begin
        out_valid_o = (state_q == ST_EMIT);
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_FIN) && !stop_i;
    end

    // Datapath next values: code, latched range end, accepted count, dwell timer
    always_comb begin
        bin_d     = bin_q;
        last_d    = last_q;
        count_d   = count_q;
        dwell_d   = dwell_q;
        aborted_d = stop_i && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bin_d   = first_i;
                    last_d  = last_i;
                    count_d = '0;
                end
            end
            ST_EMIT: begin
                if (w_hs) begin
                    count_d = count_q + c_CNT_ONE;
                    if (!stop_i && !w_final) begin
                        bin_d   = bin_q + c_BIN_ONE;
                        dwell_d = c_DWELL_LOAD;
                    end
                end
            end
            ST_DWELL: begin
                if (dwell_q != '0) dwell_d = dwell_q - 8'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            gray_q    <= '0;
            last_q    <= '0;
            count_q   <= '0;
            dwell_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            last_q    <= last_d;
            count_q   <= count_d;
            dwell_q   <= dwell_d;
            aborted_q <= aborted_d;
        end
    end

    assign bin_out_o  = bin_q;
    assign gray_out_o = gray_q;
    assign count_o    = count_q;
    assign aborted_o  = aborted_q;

endmodule
`default_nettype wire
